// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared FSM encoding and owner-id helpers for the DM arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2
    } state_e;

    // Owner id carries one extra bit so the host code never aliases a core index.
    function automatic int own_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

    // Host owner code is all ones; cast down to the actual owner width at use.
    localparam logic [3:0] OWN_HOST_MAX = 4'hF;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search starting just after ptr_i.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          vld_o,
    output logic [IW-1:0] idx_o
);

    // Scan from farthest offset to nearest so the nearest requester wins.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        for (int i = N; i >= 1; i--) begin
            if (req_i[IW'((int'(ptr_i) + i) % N)]) begin
                vld_o = 1'b1;
                idx_o = IW'((int'(ptr_i) + i) % N);
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one synchronous data memory among NUM_CORES cores and a
// host port. Host has absolute priority; cores are served round-robin.
// Optional contention counter enabled with `define DM_ARB_STATS_EN.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef DM_ARB_STATS_EN
    output logic [15:0]                 conflict_cnt,
`endif
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    input  logic                        com_req,
    input  logic                        com_wr_en,
    input  logic [ADDR_W-1:0]           com_addr,
    input  logic [DATA_W-1:0]           com_data_in,
    output logic                        com_gnt,
    output logic                        com_rvalid,
    output logic [DATA_W-1:0]           com_data_out,
    output logic [ADDR_W-1:0]           DM_addr,
    output logic [DATA_W-1:0]           DM_data_in,
    output logic                        DM_write_en,
    input  logic [DATA_W-1:0]           DM_out
);

    localparam int IW    = idx_width(NUM_CORES);
    localparam int OWN_W = own_width(NUM_CORES);
    localparam logic [OWN_W-1:0] OWN_HOST = OWN_W'(OWN_HOST_MAX);

    state_e               state_q, state_d;
    logic [OWN_W-1:0]     own_q;
    logic                 we_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [NUM_CORES-1:0] core_gnt_q, core_rvalid_q;
    logic                 com_gnt_q, com_rvalid_q;
    logic [DATA_W-1:0]    core_rdata_q, com_data_out_q, dm_wdata_q;
    logic [ADDR_W-1:0]    dm_addr_q;
    logic                 dm_we_q;

    logic                 pick_vld;
    logic [IW-1:0]        pick_idx;
    logic                 win_any, win_we;
    logic [OWN_W-1:0]     win_own;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;

    rr_picker #(.N(NUM_CORES), .IW(IW)) u_pick (
        .req_i (core_req),
        .ptr_i (rr_ptr_q),
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    // Next state plus winner selection (only meaningful in IDLE).
    always_comb begin
        state_d   = state_q;
        win_any   = 1'b0;
        win_we    = 1'b0;
        win_own   = '0;
        win_addr  = '0;
        win_wdata = '0;
        case (state_q)
            IDLE: begin
                if (com_req) begin
                    win_any   = 1'b1;
                    win_own   = OWN_HOST;
                    win_we    = com_wr_en;
                    win_addr  = com_addr;
                    win_wdata = com_data_in;
                end else if (pick_vld) begin
                    win_any   = 1'b1;
                    win_own   = {1'b0, pick_idx};
                    win_we    = core_we[pick_idx];
                    win_addr  = core_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    win_wdata = core_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                end
                if (win_any) state_d = ISSUE;
            end
            ISSUE:   state_d = we_q ? IDLE : RWAIT;
            RWAIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Latch the winner, drive DM pins, pulse gnt/rvalid, advance the RR pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            own_q          <= '0;
            we_q           <= 1'b0;
            rr_ptr_q       <= IW'(NUM_CORES - 1);
            core_gnt_q     <= '0;
            core_rvalid_q  <= '0;
            com_gnt_q      <= 1'b0;
            com_rvalid_q   <= 1'b0;
            core_rdata_q   <= '0;
            com_data_out_q <= '0;
            dm_addr_q      <= '0;
            dm_wdata_q     <= '0;
            dm_we_q        <= 1'b0;
        end else begin
            core_gnt_q    <= '0;
            core_rvalid_q <= '0;
            com_gnt_q     <= 1'b0;
            com_rvalid_q  <= 1'b0;
            dm_we_q       <= 1'b0;
            if (state_q == IDLE && win_any) begin
                own_q      <= win_own;
                we_q       <= win_we;
                dm_addr_q  <= win_addr;
                dm_wdata_q <= win_wdata;
                dm_we_q    <= win_we;
                if (win_own == OWN_HOST) com_gnt_q <= 1'b1;
                else                     core_gnt_q[win_own[IW-1:0]] <= 1'b1;
            end
            if (state_q == ISSUE && own_q != OWN_HOST)
                rr_ptr_q <= own_q[IW-1:0];
            if (state_q == RWAIT) begin
                if (own_q == OWN_HOST) begin
                    com_data_out_q <= DM_out;
                    com_rvalid_q   <= 1'b1;
                end else begin
                    core_rdata_q                <= DM_out;
                    core_rvalid_q[own_q[IW-1:0]] <= 1'b1;
                end
            end
        end
    end

    // Pulses and the DM strobe are masked while reset is low so an
    // abandoned access never writes memory or signals a requester.
    assign core_gnt     = core_gnt_q & {NUM_CORES{rst_n}};
    assign core_rvalid  = core_rvalid_q & {NUM_CORES{rst_n}};
    assign com_gnt      = com_gnt_q & rst_n;
    assign com_rvalid   = com_rvalid_q & rst_n;
    assign DM_write_en  = dm_we_q & rst_n;
    assign core_rdata   = core_rdata_q;
    assign com_data_out = com_data_out_q;
    assign DM_addr      = dm_addr_q;
    assign DM_data_in   = dm_wdata_q;

`ifdef DM_ARB_STATS_EN
    logic [15:0] cnt_q;

    // Count IDLE cycles with two or more active requesters, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (state_q == IDLE && $countones({com_req, core_req}) >= 2 && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed table of single transactions plus hand-written
// round-robin, host-priority, reset-abandon and (optional) counter sequences.
module tb_dm_arbiter;

    localparam int NC = 4;
    localparam int HOST = -1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NC-1:0]    core_req, core_we, core_gnt, core_rvalid;
    logic [NC*16-1:0] core_addr, core_wdata;
    logic [15:0]      core_rdata;
    logic             com_req, com_wr_en, com_gnt, com_rvalid;
    logic [15:0]      com_addr, com_data_in, com_data_out;
    logic [15:0]      DM_addr, DM_data_in, DM_out;
    logic             DM_write_en;
`ifdef DM_ARB_STATS_EN
    logic [15:0]      conflict_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    dm_arbiter #(.NUM_CORES(NC), .DATA_W(16), .ADDR_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef DM_ARB_STATS_EN
        .conflict_cnt (conflict_cnt),
`endif
        .core_req     (core_req),
        .core_we      (core_we),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_gnt     (core_gnt),
        .core_rvalid  (core_rvalid),
        .core_rdata   (core_rdata),
        .com_req      (com_req),
        .com_wr_en    (com_wr_en),
        .com_addr     (com_addr),
        .com_data_in  (com_data_in),
        .com_gnt      (com_gnt),
        .com_rvalid   (com_rvalid),
        .com_data_out (com_data_out),
        .DM_addr      (DM_addr),
        .DM_data_in   (DM_data_in),
        .DM_write_en  (DM_write_en),
        .DM_out       (DM_out)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory model, 256 words.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (DM_write_en) mem[DM_addr[7:0]] <= DM_data_in;
        DM_out <= mem[DM_addr[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          who;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    // Drive a single request, check gnt at T+1, DM pins, and rvalid/data at T+3.
    task automatic do_txn(input vec_t v);
        int n;
        logic g;
        @(posedge clk); #1;
        if (v.who == HOST) begin
            com_req = 1'b1; com_wr_en = v.we; com_addr = v.addr; com_data_in = v.wdata;
        end else begin
            core_req[v.who] = 1'b1; core_we[v.who] = v.we;
            core_addr[v.who*16 +: 16] = v.addr; core_wdata[v.who*16 +: 16] = v.wdata;
        end
        @(negedge clk);
        n = 0; g = 1'b0;
        while (!g && n < 8) begin
            @(negedge clk); n++;
            g = (v.who == HOST) ? com_gnt : core_gnt[v.who];
        end
        com_req = 1'b0; core_req = '0;
        chk($sformatf("gnt_latency who=%0d", v.who), n, 1);
        chk("gnt_dm_we", DM_write_en, v.we);
        chk("gnt_dm_addr", DM_addr, v.addr);
        if (v.we) begin
            chk("gnt_dm_wdata", DM_data_in, v.wdata);
            @(negedge clk);
            chk("we_drop_t2", DM_write_en, 1'b0);
        end else begin
            @(negedge clk);
            chk("rvalid_early", {com_rvalid, core_rvalid}, '0);
            @(negedge clk);
            if (v.who == HOST) begin
                chk("com_rvalid", com_rvalid, 1'b1);
                chk("com_data_out", com_data_out, v.exp_rd);
            end else begin
                chk("core_rvalid", core_rvalid, 32'(1 << v.who));
                chk("core_rdata", core_rdata, v.exp_rd);
            end
        end
    endtask

    initial begin
        int got[$];
        int exp_rr[6];
        int n;
        rst_n = 1'b0; core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        com_req = 1'b0; com_wr_en = 1'b0; com_addr = '0; com_data_in = '0;

        vecs[0] = '{2,    1'b1, 16'h0040, 16'hBEEF, 16'h0000};
        vecs[1] = '{1,    1'b0, 16'h0040, 16'h0000, 16'hBEEF};
        vecs[2] = '{0,    1'b1, 16'h0010, 16'h1234, 16'h0000};
        vecs[3] = '{HOST, 1'b1, 16'h0011, 16'h5678, 16'h0000};
        vecs[4] = '{3,    1'b0, 16'h0010, 16'h0000, 16'h1234};
        vecs[5] = '{HOST, 1'b0, 16'h0011, 16'h0000, 16'h5678};
        vecs[6] = '{1,    1'b1, 16'h00FF, 16'hA5A5, 16'h0000};
        vecs[7] = '{HOST, 1'b0, 16'h00FF, 16'h0000, 16'hA5A5};
        vecs[8] = '{0,    1'b1, 16'h0050, 16'h1111, 16'h0000};
        vecs[9] = '{3,    1'b1, 16'h0020, 16'hCAFE, 16'h0000};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_core_gnt", core_gnt, '0);
        chk("rst_com_gnt", com_gnt, 1'b0);
        chk("rst_rvalid", {com_rvalid, core_rvalid}, '0);
        chk("rst_dm_we", DM_write_en, 1'b0);
        chk("rst_dm_addr", DM_addr, 16'h0);
        chk("rst_dm_wdata", DM_data_in, 16'h0);
        chk("rst_core_rdata", core_rdata, 16'h0);
        chk("rst_com_data_out", com_data_out, 16'h0);

        for (int i = 0; i < 10; i++) do_txn(vecs[i]);

        // Round robin: cores 0,1,3 request continuously from a fresh pointer.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        exp_rr = '{0, 1, 3, 0, 1, 3};
        core_we = 4'b1011; core_req = 4'b1011;
        core_addr[0*16 +: 16] = 16'h0080; core_addr[1*16 +: 16] = 16'h0081; core_addr[3*16 +: 16] = 16'h0083;
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            @(negedge clk);
            if (|core_gnt) begin
                chk("rr_onehot", $countones(core_gnt), 1);
                for (int k = 0; k < NC; k++) if (core_gnt[k]) got.push_back(k);
            end
        end
        core_req = '0;
        chk("rr_count", got.size(), 6);
        for (int k = 0; k < 6 && k < got.size(); k++)
            chk($sformatf("rr_order[%0d]", k), got[k], exp_rr[k]);

        // Host priority: host read and core 0 write raised together.
        @(posedge clk); @(posedge clk); #1;
        com_req = 1'b1; com_wr_en = 1'b0; com_addr = 16'h0040;
        core_req[0] = 1'b1; core_we[0] = 1'b1; core_addr[0 +: 16] = 16'h0030; core_wdata[0 +: 16] = 16'h1111;
        @(negedge clk);
        @(negedge clk);
        chk("hp_com_gnt_t1", com_gnt, 1'b1);
        chk("hp_core_gnt_t1", core_gnt, '0);
        com_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("hp_com_rvalid_t3", com_rvalid, 1'b1);
        chk("hp_com_data_out", com_data_out, 16'hBEEF);
        chk("hp_core_gnt_t3", core_gnt, '0);
        @(negedge clk);
        chk("hp_core0_gnt_t4", core_gnt, 4'b0001);
        core_req = '0;
        repeat (3) @(negedge clk);
        chk("com_data_out_held", com_data_out, 16'hBEEF);

        // Reset during ISSUE of a core 1 write: strobe masked, nothing follows.
        @(posedge clk); #1;
        core_req[1] = 1'b1; core_we[1] = 1'b1; core_addr[16 +: 16] = 16'h0050; core_wdata[16 +: 16] = 16'h7777;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_gnt", core_gnt, 4'b0010);
        core_req = '0; rst_n = 1'b0;
        #1 chk("rst_mid_we_masked", DM_write_en, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (|{com_rvalid, core_rvalid, com_gnt, core_gnt}) n++;
        end
        chk("rst_mid_no_pulses", n, 0);
        @(posedge clk); #1;
        core_req = 4'b0011; core_we = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_core0_first", core_gnt, 4'b0001);
        core_req = '0;
        @(negedge clk);
        do_txn('{2, 1'b0, 16'h0050, 16'h0000, 16'h1111});

`ifdef DM_ARB_STATS_EN
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        com_req = 1'b1; com_wr_en = 1'b1; com_addr = 16'h0090; core_req = 4'b0011; core_we = 4'b0011;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        com_req = 1'b0; core_req = '0;
        @(negedge clk);
        chk("stats_cnt2", conflict_cnt, 16'd2);
        repeat (4) @(posedge clk);
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        @(posedge clk); #1;
        com_req = 1'b1; core_req = 4'b0001;
        repeat (8) @(posedge clk);
        #1 com_req = 1'b0; core_req = '0;
        @(negedge clk);
        chk("stats_saturate", conflict_cnt, 16'hFFFF);
`endif

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single 16-bit data memory (DM) among NUM_CORES core load/store ports plus one host (com) port.
- Host port has absolute priority, used for program/data load and readback. Cores are served round-robin.
- Sits between the core LSUs / com interface and the DM. Drives the DM address/data/write-enable pins that were previously muxed by status.
- Registered outputs; one DM access in flight at a time.

Parameters:
- NUM_CORES, 4, number of core requesters (2..8)
- DATA_W, 16, DM data width
- ADDR_W, 16, DM address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- core_req  in  NUM_CORES  per-core access request, level, held until gnt
- core_we  in  NUM_CORES  per-core write (1) / read (0)
- core_addr  in  NUM_CORES*ADDR_W  packed per-core address, core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  packed per-core write data
- core_gnt  out  NUM_CORES  one-hot, one-cycle grant pulse
- core_rvalid  out  NUM_CORES  one-cycle read-data-valid pulse to the requester
- core_rdata  out  DATA_W  read data, shared; qualified by core_rvalid
- com_req  in  1  host request, level
- com_wr_en  in  1  host write/read
- com_addr  in  ADDR_W  host address
- com_data_in  in  DATA_W  host write data
- com_gnt  out  1  host grant pulse
- com_rvalid  out  1  host read-data-valid pulse
- com_data_out  out  DATA_W  host read data, held until next host read
- DM_addr  out  ADDR_W  to DM
- DM_data_in  out  DATA_W  to DM
- DM_write_en  out  1  to DM
- DM_out  in  DATA_W  DM synchronous read data, valid one cycle after address

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; all gnt/rvalid=0; DM_write_en=0; DM_addr, DM_data_in, core_rdata, com_data_out=0; rr_ptr=NUM_CORES-1, so core 0 wins first.
- FSM states: IDLE, ISSUE, RWAIT.
- IDLE at cycle T:
  - If com_req=1, the host wins. Otherwise the first core_req set, searching from rr_ptr+1 modulo NUM_CORES, wins. If nothing is requesting, stay in IDLE.
  - For the winner, latch we/addr/wdata and an owner id; go to ISSUE.
- ISSUE at T+1:
  - gnt pulse to the owner. DM_addr and DM_data_in carry the latched values; DM_write_en = latched we.
  - If the owner is a core, rr_ptr <= owner.
  - Write: next state IDLE. Read: next state RWAIT.
- RWAIT at T+2:
  - DM_write_en=0. DM_out is registered into core_rdata (core owner) or com_data_out (host).
  - rvalid pulse to the owner at T+3, coinciding with IDLE.
- Latency and throughput:
  - Write: req at T, gnt at T+1; next arbitration at T+2.
  - Read: req at T, gnt at T+1, rvalid at T+3. Arbitration in the same T+3 cycle, so a new ISSUE occurs at T+4.
- Requester rules:
  - A requester must keep req and its fields stable until it sees gnt. After gnt it may change them.
  - A req still high the cycle after gnt is a new request.
- DM_write_en is 1 only in ISSUE with a write. DM_addr and DM_data_in hold their last values otherwise.
- core_rdata holds its value until the next core read completes.
- Host starvation of cores is permitted; the host is assumed bursty.
- Round-robin wrap: rr_ptr=NUM_CORES-1 searches from core 0.
- Simultaneous core requests: the search order from rr_ptr+1 decides. Every requesting core is served within NUM_CORES grants when com_req=0.
- Reset mid-transaction: the access is abandoned. No gnt or rvalid issues after reset, and any DM write in the reset cycle is suppressed.

Optional Feature:
- Macro DM_ARB_STATS_EN.
- Defined: adds output conflict_cnt (16 bits). It increments each IDLE cycle in which two or more requesters (com included) are active, and saturates at 16'hFFFF. Reset value 0.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Package dm_arb_pkg holds:
  - the state encoding (IDLE=2'd0, ISSUE=2'd1, RWAIT=2'd2);
  - the owner id width, $clog2(NUM_CORES)+1;
  - the host owner code (all ones).
- Sub-module rr_picker: combinational round-robin search; inputs req vector and pointer, outputs valid and index.

Test Plan:
- Core 2 write addr 16'h0040, data 16'hBEEF:
  - gnt[2] at T+1 with DM_write_en=1, DM_addr=16'h0040, DM_data_in=16'hBEEF.
  - DM_write_en=0 at T+2.
- Core 1 read 16'h0040 after that write: gnt[1] at T+1, core_rvalid[1] at T+3 with core_rdata=16'hBEEF.
- Cores 0,1,3 all request continuously (4 cores): grant order 0,1,3,0,1,3. No core receives two grants before the others are served.
- com_req and core_req[0] raised together, host read 16'h0040: com_gnt first; com_rvalid at T+3 with com_data_out=16'hBEEF; core 0 granted at T+4.
- rst_n=0 asserted for one edge during ISSUE of a write:
  - No core_rvalid or com_rvalid follows, and DM_write_en is 0 in the reset cycle.
  - The next request is granted to core 0 first.
- With DM_ARB_STATS_EN: 3 requesters active for 2 IDLE cycles -> conflict_cnt=2. Preload near 16'hFFFF and verify saturation.
